// File: rtl/snake_dir_queue.sv
// snake_dir_queue
// ---------------
// Multi-player direction controller for the snake game. Each player channel
// turns button presses into direction changes, buffering pending turns in a
// small circular FIFO so that two quick turns between game ticks are both
// honoured. Each game tick (pulse) consumes at most one queued turn.
//
// Direction encoding (direction_t): STOP=0, LEFT=1, RIGHT=2, DOWN=3, UP=4.
//
// Ports:
//   clk          system clock
//   nrst         asynchronous active-low reset
//   buttons      4 bits per player, one-hot: bit0 LEFT, bit1 RIGHT, bit2 DOWN, bit3 UP
//   sync         game restart/death: all players to STOP, queues flushed
//   pulse        game tick, one cycle wide; pops one queued turn per player
//   pause        while high, pulse is ignored (presses are still queued)
//   direction    3 bits per player, current direction
//   queue_count  3 bits per player, occupied FIFO entries
//   drop         1 bit per player, one-cycle strobe when a valid press hits a full FIFO
module snake_dir_queue #(
    parameter int NUM_PLAYERS   = 2,
    parameter int QUEUE_DEPTH   = 2,
    parameter int ALLOW_REVERSE = 0
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic [4*NUM_PLAYERS-1:0]   buttons,
    input  logic                       sync,
    input  logic                       pulse,
    input  logic                       pause,
    output logic [3*NUM_PLAYERS-1:0]   direction,
    output logic [3*NUM_PLAYERS-1:0]   queue_count,
    output logic [NUM_PLAYERS-1:0]     drop
);

    typedef enum logic [2:0] {
        STOP  = 3'd0,
        LEFT  = 3'd1,
        RIGHT = 3'd2,
        DOWN  = 3'd3,
        UP    = 3'd4
    } direction_t;

    // A depth of 1 still needs a one-bit pointer to keep the declarations legal.
    localparam int              PW         = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam logic [PW-1:0]   LAST_PTR   = PW'(QUEUE_DEPTH - 1);
    localparam logic [2:0]      FULL_COUNT = 3'(QUEUE_DEPTH);

    function automatic direction_t decode_button(input logic [3:0] b);
        direction_t d;
        case (b)
            4'b0001: d = LEFT;
            4'b0010: d = RIGHT;
            4'b0100: d = DOWN;
            4'b1000: d = UP;
            default: d = STOP;
        endcase
        return d;
    endfunction

    function automatic direction_t opposite(input direction_t d);
        direction_t o;
        case (d)
            LEFT:    o = RIGHT;
            RIGHT:   o = LEFT;
            DOWN:    o = UP;
            UP:      o = DOWN;
            default: o = STOP;
        endcase
        return o;
    endfunction

    // Explicit wrap so non-power-of-two depths (e.g. 3) cycle correctly.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PW-1:0] prev_ptr(input logic [PW-1:0] p);
        return (p == '0) ? LAST_PTR : p - 1'b1;
    endfunction

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_player
        logic [3:0]    btn;
        logic [3:0]    prev_btn;
        direction_t    dir_q;
        direction_t    tail;
        direction_t    press_dir;
        direction_t    fifo_mem [QUEUE_DEPTH];
        logic [PW-1:0] rd_ptr;
        logic [PW-1:0] wr_ptr;
        logic [2:0]    count;
        logic          drop_q;
        logic          press;
        logic          accept;
        logic          pop;
        logic          push;
        logic          overflow;

        assign btn = buttons[4*g +: 4];

        // Press detection and validation. A press is a transition from an
        // all-released vector to a one-hot vector. It is checked against the
        // tail: the newest queued turn, or the live direction when the queue
        // is empty. When a pop and push coincide, the tail is still the
        // pre-pop newest entry, which keeps the check consistent.
        always_comb begin
            press     = (prev_btn == 4'b0000) && $onehot(btn);
            press_dir = decode_button(btn);
            tail      = (count != 3'd0) ? fifo_mem[prev_ptr(wr_ptr)] : dir_q;
            pop       = pulse && !pause && (count != 3'd0);
            accept    = press && (press_dir != tail) &&
                        ((tail == STOP) || (ALLOW_REVERSE != 0) ||
                         (press_dir != opposite(tail)));
            push      = accept && ((count != FULL_COUNT) || pop);
            overflow  = accept && (count == FULL_COUNT) && !pop;
        end

        // Channel state. sync overrides everything except the press-edge
        // register, which keeps sampling so a button held through a restart
        // does not fire again afterwards.
        always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
                prev_btn <= 4'b0000;
                dir_q    <= STOP;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= 3'd0;
                drop_q   <= 1'b0;
            end else begin
                prev_btn <= btn;
                if (sync) begin
                    dir_q  <= STOP;
                    rd_ptr <= '0;
                    wr_ptr <= '0;
                    count  <= 3'd0;
                    drop_q <= 1'b0;
                end else begin
                    drop_q <= overflow;
                    if (pop) begin
                        dir_q  <= fifo_mem[rd_ptr];
                        rd_ptr <= next_ptr(rd_ptr);
                    end
                    if (push) begin
                        wr_ptr <= next_ptr(wr_ptr);
                    end
                    if (push && !pop) begin
                        count <= count + 3'd1;
                    end else if (pop && !push) begin
                        count <= count - 3'd1;
                    end
                end
            end
        end

        // FIFO storage needs no reset: an entry is only ever read after
        // being written, since count gates every read.
        always_ff @(posedge clk) begin
            if (push && !sync) begin
                fifo_mem[wr_ptr] <= press_dir;
            end
        end

        assign direction[3*g +: 3]   = dir_q;
        assign queue_count[3*g +: 3] = count;
        assign drop[g]               = drop_q;
    end

endmodule

// File: tb/tb_snake_dir_queue.sv
// tb_snake_dir_queue
// ------------------
// Testbench for snake_dir_queue. Three instances share one stimulus stream:
//   dut_a: 2 players, depth 2, reversal rejected
//   dut_r: 2 players, depth 2, reversal allowed
//   dut_m: 2 players, depth 3, reversal rejected
// A queue-based model of every channel is checked against all outputs on
// each falling edge; directed literal expectations pin the model.
module tb_snake_dir_queue;

    localparam int STOP = 0, LEFT = 1, RIGHT = 2, DOWN = 3, UP = 4;
    localparam logic [3:0] B_0 = 4'b0000, B_L = 4'b0001, B_R = 4'b0010,
                           B_D = 4'b0100, B_U = 4'b1000;

    logic       clk = 1'b0;
    logic       nrst = 1'b1;
    logic [7:0] buttons = 8'h00;
    logic       sync = 1'b0;
    logic       pulse = 1'b0;
    logic       pause = 1'b0;

    logic [5:0] dir_a, dir_r, dir_m;
    logic [5:0] cnt_a, cnt_r, cnt_m;
    logic [1:0] drop_a, drop_r, drop_m;

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    snake_dir_queue #(.NUM_PLAYERS(2), .QUEUE_DEPTH(2), .ALLOW_REVERSE(0)) dut_a (
        .clk(clk), .nrst(nrst), .buttons(buttons), .sync(sync), .pulse(pulse),
        .pause(pause), .direction(dir_a), .queue_count(cnt_a), .drop(drop_a));

    snake_dir_queue #(.NUM_PLAYERS(2), .QUEUE_DEPTH(2), .ALLOW_REVERSE(1)) dut_r (
        .clk(clk), .nrst(nrst), .buttons(buttons), .sync(sync), .pulse(pulse),
        .pause(pause), .direction(dir_r), .queue_count(cnt_r), .drop(drop_r));

    snake_dir_queue #(.NUM_PLAYERS(2), .QUEUE_DEPTH(3), .ALLOW_REVERSE(0)) dut_m (
        .clk(clk), .nrst(nrst), .buttons(buttons), .sync(sync), .pulse(pulse),
        .pause(pause), .direction(dir_m), .queue_count(cnt_m), .drop(drop_m));

    // Model: channel k = instance*2 + player; queue holds pending turns.
    int         depth_of [3] = '{2, 2, 3};
    int         rev_of   [3] = '{0, 1, 0};
    int         mdir  [6];
    int         mq    [6][$];
    logic [3:0] mprev [6];
    int         mdrop [6];

    function automatic int opp(input int d);
        case (d)
            LEFT:    return RIGHT;
            RIGHT:   return LEFT;
            DOWN:    return UP;
            UP:      return DOWN;
            default: return STOP;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 6; k++) begin
            mdir[k]  = STOP;
            mq[k].delete();
            mprev[k] = 4'b0000;
            mdrop[k] = 0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 6; k++) begin
            int         inst;
            int         p;
            logic [3:0] b;
            int         pd;
            int         tail;
            bit         press;
            bit         acc;
            bit         pop;
            inst = k / 2;
            p    = k % 2;
            b    = buttons[4*p +: 4];
            mdrop[k] = 0;
            if (sync) begin
                mdir[k] = STOP;
                mq[k].delete();
            end else begin
                press = (mprev[k] == 4'b0000) && ($countones(b) == 1);
                pd = STOP;
                for (int j = 0; j < 4; j++) if (b[j]) pd = j + 1;
                tail = (mq[k].size() > 0) ? mq[k][$] : mdir[k];
                acc  = press && (pd != tail) &&
                       (tail == STOP || rev_of[inst] == 1 || pd != opp(tail));
                pop  = pulse && !pause && (mq[k].size() > 0);
                if (pop) mdir[k] = mq[k].pop_front();
                if (acc) begin
                    if (mq[k].size() < depth_of[inst]) mq[k].push_back(pd);
                    else mdrop[k] = 1;
                end
            end
            mprev[k] = b;
        end
    endtask

    always @(posedge clk or negedge nrst) begin
        if (!nrst) model_reset();
        else       model_step();
    end

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic compare_inst(input int inst, input logic [5:0] d,
                                input logic [5:0] c, input logic [1:0] dr);
        for (int p = 0; p < 2; p++) begin
            check_output($sformatf("model dir i%0d p%0d", inst, p),
                         int'(d[3*p +: 3]), mdir[inst*2+p]);
            check_output($sformatf("model count i%0d p%0d", inst, p),
                         int'(c[3*p +: 3]), mq[inst*2+p].size());
            check_output($sformatf("model drop i%0d p%0d", inst, p),
                         int'(dr[p]), mdrop[inst*2+p]);
        end
    endtask

    // Every falling edge: all outputs of all instances against the model.
    always @(negedge clk) begin
        if (check_en) begin
            compare_inst(0, dir_a, cnt_a, drop_a);
            compare_inst(1, dir_r, cnt_r, drop_r);
            compare_inst(2, dir_m, cnt_m, drop_m);
        end
    end

    // One cycle of stimulus: drive, cross a rising edge, settle 2 time units.
    task automatic apply_stimulus(input logic [3:0] b0, input logic [3:0] b1,
                                  input logic s, input logic pl, input logic pa);
        buttons = {b1, b0};
        sync    = s;
        pulse   = pl;
        pause   = pa;
        @(posedge clk);
        #2;
    endtask

    initial begin
        model_reset();
        #1 nrst = 1'b0;
        #1;
        check_output("reset direction", int'(dir_a), 0);
        check_output("reset count", int'(cnt_a), 0);
        check_output("reset drop", int'(drop_a), 0);
        check_en = 1'b1;
        #10 nrst = 1'b1;
        @(posedge clk);
        #2;

        // Press and pulse together on an empty queue: no bypass.
        apply_stimulus(B_R, B_0, 0, 1, 0);
        check_output("no bypass dir", int'(dir_a[2:0]), STOP);
        check_output("no bypass count", int'(cnt_a[2:0]), 1);
        apply_stimulus(B_0, B_0, 0, 1, 0);
        check_output("first turn RIGHT", int'(dir_a[2:0]), RIGHT);

        // Double turn between ticks.
        apply_stimulus(B_U, B_0, 0, 0, 0);
        apply_stimulus(B_0, B_0, 0, 0, 0);
        apply_stimulus(B_0, B_0, 0, 0, 0);
        apply_stimulus(B_L, B_0, 0, 0, 0);
        check_output("double turn count", int'(cnt_a[2:0]), 2);
        apply_stimulus(B_0, B_0, 0, 1, 0);
        check_output("double turn tick1", int'(dir_a[2:0]), UP);
        apply_stimulus(B_0, B_0, 0, 1, 0);
        check_output("double turn tick2", int'(dir_a[2:0]), LEFT);
        apply_stimulus(B_0, B_0, 0, 1, 0);
        check_output("double turn tick3 dir", int'(dir_a[2:0]), LEFT);
        check_output("double turn tick3 count", int'(cnt_a[2:0]), 0);

        // Reversal and duplicate rejection (direction LEFT).
        apply_stimulus(B_R, B_0, 0, 0, 0);
        check_output("reverse rejected count", int'(cnt_a[2:0]), 0);
        check_output("reverse rejected drop", int'(drop_a[0]), 0);
        check_output("reverse allowed count", int'(cnt_r[2:0]), 1);
        apply_stimulus(B_0, B_0, 0, 0, 0);
        apply_stimulus(B_U, B_0, 0, 0, 0);
        check_output("queue UP count", int'(cnt_a[2:0]), 1);
        apply_stimulus(B_0, B_0, 0, 0, 0);
        apply_stimulus(B_D, B_0, 0, 0, 0);
        check_output("opposite of tail", int'(cnt_a[2:0]), 1);
        check_output("opposite of tail drop", int'(drop_a[0]), 0);
        apply_stimulus(B_0, B_0, 0, 0, 0);
        apply_stimulus(B_U, B_0, 0, 0, 0);
        check_output("duplicate of tail", int'(cnt_a[2:0]), 1);
        apply_stimulus(B_0, B_0, 0, 0, 0);

        // Overflow and simultaneous pop/push, getting back to RIGHT first.
        apply_stimulus(B_0, B_0, 0, 1, 0);
        check_output("drain to UP", int'(dir_a[2:0]), UP);
        apply_stimulus(B_R, B_0, 0, 0, 0);
        apply_stimulus(B_0, B_0, 0, 1, 0);
        check_output("back to RIGHT", int'(dir_a[2:0]), RIGHT);
        apply_stimulus(B_U, B_0, 0, 0, 0);
        apply_stimulus(B_0, B_0, 0, 0, 0);
        apply_stimulus(B_L, B_0, 0, 0, 0);
        apply_stimulus(B_0, B_0, 0, 0, 0);
        check_output("full count", int'(cnt_a[2:0]), 2);
        apply_stimulus(B_D, B_0, 0, 0, 0);
        check_output("overflow drop", int'(drop_a[0]), 1);
        check_output("overflow count", int'(cnt_a[2:0]), 2);
        apply_stimulus(B_0, B_0, 0, 0, 0);
        check_output("drop one cycle", int'(drop_a[0]), 0);
        apply_stimulus(B_D, B_0, 0, 1, 0);
        check_output("pop+push dir", int'(dir_a[2:0]), UP);
        check_output("pop+push count", int'(cnt_a[2:0]), 2);
        check_output("pop+push drop", int'(drop_a[0]), 0);
        apply_stimulus(B_0, B_0, 0, 1, 0);
        check_output("fifo head LEFT", int'(dir_a[2:0]), LEFT);
        apply_stimulus(B_0, B_0, 0, 1, 0);
        check_output("fifo next DOWN", int'(dir_a[2:0]), DOWN);
        check_output("fifo empty", int'(cnt_a[2:0]), 0);

        // Pause masks ticks; sync beats pulse and presses.
        apply_stimulus(B_L, B_0, 0, 0, 0);
        apply_stimulus(B_0, B_0, 0, 0, 0);
        apply_stimulus(B_U, B_0, 0, 0, 0);
        apply_stimulus(B_0, B_0, 0, 0, 0);
        for (int t = 0; t < 3; t++) apply_stimulus(B_0, B_0, 0, 1, 1);
        check_output("paused dir", int'(dir_a[2:0]), DOWN);
        check_output("paused count", int'(cnt_a[2:0]), 2);
        apply_stimulus(B_R, B_U, 1, 1, 0);
        check_output("sync dir a", int'(dir_a), 0);
        check_output("sync count a", int'(cnt_a), 0);
        check_output("sync drop a", int'(drop_a), 0);
        check_output("sync dir r", int'(dir_r), 0);
        check_output("sync count m", int'(cnt_m), 0);
        apply_stimulus(B_R, B_U, 0, 0, 0);
        check_output("held through sync", int'(cnt_a), 0);
        apply_stimulus(B_0, B_0, 0, 0, 0);

        // Independent players, depth 3, non-one-hot vector on P1.
        apply_stimulus(B_R, B_U, 0, 0, 0);
        apply_stimulus(B_0, B_0, 0, 0, 0);
        apply_stimulus(B_D, 4'b0011, 0, 0, 0);
        check_output("non-one-hot ignored", int'(cnt_m[5:3]), 1);
        apply_stimulus(B_0, B_0, 0, 0, 0);
        apply_stimulus(B_L, B_L, 0, 0, 0);
        check_output("depth3 p0 count", int'(cnt_m[2:0]), 3);
        check_output("depth3 p1 count", int'(cnt_m[5:3]), 2);
        apply_stimulus(B_0, B_0, 0, 1, 0);
        check_output("p0 tick1", int'(dir_m[2:0]), RIGHT);
        check_output("p1 tick1", int'(dir_m[5:3]), UP);
        apply_stimulus(B_0, B_0, 0, 1, 0);
        check_output("p0 tick2", int'(dir_m[2:0]), DOWN);
        apply_stimulus(B_0, B_0, 0, 1, 0);
        check_output("p0 tick3", int'(dir_m[2:0]), LEFT);
        check_output("p1 tick3", int'(dir_m[5:3]), LEFT);

        // Asynchronous reset with entries queued, released between edges.
        apply_stimulus(B_U, B_D, 0, 0, 0);
        apply_stimulus(B_0, B_0, 0, 0, 0);
        check_output("queued before reset", int'(cnt_m[2:0]), 1);
        #1 nrst = 1'b0;
        #1;
        check_output("async reset dir", int'(dir_a), 0);
        check_output("async reset count a", int'(cnt_a), 0);
        check_output("async reset count m", int'(cnt_m), 0);
        check_output("async reset drop", int'(drop_m), 0);
        @(posedge clk);
        #3 nrst = 1'b1;
        @(posedge clk);
        #2;
        apply_stimulus(B_0, B_0, 0, 1, 0);
        check_output("pulse after reset", int'(dir_a), 0);

        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/snake_dir_queue.md
Name: snake_dir_queue

Overview:
Multi-player direction controller for the snake game. It generalises the single-player direction FSM to NUM_PLAYERS channels. Each channel buffers button presses in a small FIFO, so that two quick turns between game ticks are both honoured. Each channel applies a configurable reversal rule. The block sits between the synchronised button inputs and the snake movement/position logic, and outputs one direction per player in the shared direction_t encoding.

Parameters:
NUM_PLAYERS, 2, number of independent player channels (1..4)
QUEUE_DEPTH, 2, pending-turn FIFO entries per player (1..4)
ALLOW_REVERSE, 0, 1 = 180-degree turns accepted; 0 = rejected

Ports:
clk  in  1  system clock
nrst  in  1  asynchronous active-low reset
buttons  in  4*NUM_PLAYERS  per player, one-hot: bit0 LEFT, bit1 RIGHT, bit2 DOWN, bit3 UP
sync  in  1  game restart/death; forces all players to STOP and flushes the queues
pulse  in  1  game tick, one cycle wide; consumes one queued turn per player
pause  in  1  while high, pulse is ignored
direction  out  3*NUM_PLAYERS  current direction per player (direction_t)
queue_count  out  3*NUM_PLAYERS  occupied FIFO entries per player
drop  out  NUM_PLAYERS  one-cycle strobe when a valid press is lost to a full FIFO

Behaviour:
- Clock, reset, outputs: one clock. Reset is asynchronous and active-low (nrst). On reset: every direction = STOP; all FIFOs empty; queue_count = 0; drop = 0; the press-edge registers are cleared to 4'b0000.
- Press detection (per player): a register holds the previous button vector. A press is an edge where the previous vector is 0 and the current vector is exactly one-hot. Non-one-hot vectors are ignored. A held button produces one press only.
- Tail: tail = newest FIFO entry if count > 0, otherwise the current direction.
- Validation: a press is rejected when any of the following holds:
  - its direction equals tail (duplicate);
  - ALLOW_REVERSE = 0 and it is the opposite of tail.
  - When tail = STOP, any direction is accepted.
  - Rejected presses are dropped silently, with no drop strobe.
- Enqueue: an accepted press is written at the same clock edge the press is detected. If count = QUEUE_DEPTH and no pop occurs that cycle, the press is discarded and drop pulses high for exactly one cycle.
- Dequeue: when pulse = 1, pause = 0 and count > 0, the head entry becomes direction at that edge and count decrements. With pulse and count = 0, direction holds (the snake keeps moving).
- Simultaneous pop and push: both happen in the same cycle and count is unchanged. A full FIFO accepts the push when a pop occurs that cycle. Tail is still the pre-pop newest entry; when count was 1, that entry equals the new direction, so the result is consistent.
- Latency: press in cycle n -> entry visible in queue_count after edge n. The earliest pulse in cycle n+1 updates direction after edge n+1. A press and a pulse in the same cycle with an empty FIFO do not bypass: the direction changes on the next pulse.
- sync has highest priority:
  - At the edge where sync = 1, every direction becomes STOP and every FIFO is flushed (count = 0).
  - Presses and pulse in that cycle are discarded and drop stays 0.
  - Edge registers still sample, so a button held through sync does not re-fire.
- pause: it only masks pulse. Presses are still validated and queued while paused.
- Independence: channels share only sync, pulse and pause. No state crosses between players.
- FIFO implementation: circular buffer with read/write pointers that wrap modulo QUEUE_DEPTH. The count register is 0..QUEUE_DEPTH. Pointer wrap must be correct for non-power-of-two depths (e.g. 3).

Test Plan:
1. Reset check: assert nrst = 0 mid-run with entries queued, releasing it between clock edges -> direction = STOP, queue_count = 0 and drop = 0 immediately (asynchronous). The first pulse after release leaves direction = STOP.
2. Double turn: P0 direction RIGHT, press UP (cycle 0), release, press LEFT (cycle 3) -> queue_count = 2. The first pulse gives UP, the second gives LEFT, the third leaves LEFT with count = 0.
3. Reversal and duplicate rejection:
   - ALLOW_REVERSE = 0, direction RIGHT, press LEFT -> count stays 0, drop = 0.
   - Queue UP, then press DOWN -> rejected. Press UP again -> rejected.
   - Rebuild with ALLOW_REVERSE = 1: LEFT is accepted.
4. Overflow and simultaneous events, QUEUE_DEPTH = 2, direction RIGHT:
   - Queue UP, LEFT, then press DOWN -> drop high for one cycle, count = 2.
   - Repeat with DOWN pressed in the same cycle as pulse -> direction = UP, count stays 2, FIFO = {LEFT, DOWN}, drop = 0.
5. sync and pause:
   - With 2 queued turns, raise pause and pulse for 3 ticks -> direction unchanged, count = 2.
   - Assert sync together with pulse and a new press -> direction = STOP, count = 0, drop = 0 on all players.
6. Multi-player independence (NUM_PLAYERS = 2, QUEUE_DEPTH = 3): give P0 and P1 different press streams, including a non-one-hot vector (4'b0011) on P1 -> each channel's sequence matches its own model, and the 4'b0011 vector causes no enqueue.
